// File: rtl/fifo_example_pkg.sv
// Purpose: constants, reader FSM encoding and saturating counter helper shared by the FIFO example.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_example_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } rd_state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_periodic_reader_tick.sv
// Purpose: free-running 0..PERIOD-1 counter with a tick in its last count (shared by read and write sides).
// Latency: first tick PERIOD-1 cycles after reset release, then every PERIOD cycles.
// Backpressure: none; the counter never stalls.
module en_period_tick #(
  parameter int unsigned PERIOD = 35
) (
  input  logic clk,
  input  logic kill,
  output logic tick
);

  localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Count up and fold back to zero right after the tick cycle.
  always_ff @(posedge clk or negedge kill) begin
    if (!kill)     r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/fifo_periodic_reader.sv
// Purpose: periodic FIFO read-side consumer; checks an incrementing word pattern (optional FIFO_READER_UNDERRUN_STATS_EN adds underrun_count).
// Latency: tick -> fifo_rd_en 1 cycle, fifo_rd_en -> data_valid 2 cycles.
// Backpressure: a read is attempted only on ticks where the FIFO is non-empty; skipped ticks are dropped.
module fifo_periodic_reader
  import fifo_example_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned           RD_EN_PERIOD = 35,
  parameter logic [DATA_WIDTH-1:0] START_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  kill,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  seq_error,
  output logic [CNT_W-1:0]      word_count,
`ifdef FIFO_READER_UNDERRUN_STATS_EN
  output logic [CNT_W-1:0]      underrun_count,
`endif
  output logic [CNT_W-1:0]      err_count
);

  // A period below 3 would let a tick land in ISSUE or CAPTURE and be lost.
  generate
    if (RD_EN_PERIOD < 3) begin : g_bad_period
      $error("fifo_periodic_reader: RD_EN_PERIOD must be >= 3");
    end
  endgenerate

  logic w_tick;

  en_period_tick #(.PERIOD(RD_EN_PERIOD)) u_tick (
    .clk  (clk),
    .kill (kill),
    .tick (w_tick)
  );

  rd_state_t r_state;
  rd_state_t w_next;
  logic      w_issue;
  logic      w_capture;
  logic      w_mismatch;

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_expected;
  logic                  r_valid;
  logic                  r_serr;
  logic [CNT_W-1:0]      r_words;
  logic [CNT_W-1:0]      r_errs;

  // State register.
  always_ff @(posedge clk or negedge kill) begin
    if (!kill) r_state <= ST_WAIT;
    else       r_state <= w_next;
  end

  // Next state: one read per non-empty tick, then a fixed issue/capture pair.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT:    if (w_tick && !fifo_empty) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_WAIT;
      default:    w_next = ST_WAIT;
    endcase
  end

  // State decode: strobe the FIFO in ISSUE, sample its data in CAPTURE.
  always_comb begin
    w_issue   = (r_state == ST_ISSUE);
    w_capture = (r_state == ST_CAPTURE);
  end

  assign fifo_rd_en = w_issue;
  assign w_mismatch = w_capture && (fifo_dout != r_expected);

  // Capture path; the expected word follows the received one so a single gap costs one error.
  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      r_data     <= '0;
      r_expected <= START_VALUE;
      r_valid    <= 1'b0;
      r_serr     <= 1'b0;
      r_words    <= '0;
      r_errs     <= '0;
    end else begin
      r_valid <= w_capture;
      r_serr  <= w_mismatch;
      if (w_capture) begin
        r_data     <= fifo_dout;
        r_expected <= fifo_dout + DATA_WIDTH'(1);
        r_words    <= r_words + CNT_W'(1);
      end
      if (w_mismatch) r_errs <= sat_inc(r_errs);
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign seq_error  = r_serr;
  assign word_count = r_words;
  assign err_count  = r_errs;

`ifdef FIFO_READER_UNDERRUN_STATS_EN
  logic [CNT_W-1:0] r_underruns;

  // Count ticks that found the FIFO empty.
  always_ff @(posedge clk or negedge kill) begin
    if (!kill)                   r_underruns <= '0;
    else if (w_tick && fifo_empty) r_underruns <= sat_inc(r_underruns);
  end

  assign underrun_count = r_underruns;
`endif

endmodule

// File: tb/tb_fifo_periodic_reader.sv
// Purpose: self-checking bench for fifo_periodic_reader against a cycle-arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_fifo_periodic_reader;

  localparam int          DW = 12;
  localparam int          P0 = 35;
  localparam int          P1 = 7;
  localparam logic [11:0] S0 = 12'h000;
  localparam logic [11:0] S1 = 12'hFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        kill;
  logic        empty0, empty1, rd0, rd1, dv0, dv1, se0, se1;
  logic [11:0] dout0, dout1, dat0, dat1;
  logic [15:0] wc0, wc1, ec0, ec1;
`ifdef FIFO_READER_UNDERRUN_STATS_EN
  logic [15:0] uc0, uc1;
`endif

  fifo_periodic_reader #(.DATA_WIDTH(DW), .RD_EN_PERIOD(P0), .START_VALUE(S0)) u_dut0 (
    .clk(clk), .kill(kill), .fifo_empty(empty0), .fifo_rd_en(rd0), .fifo_dout(dout0),
    .data_out(dat0), .data_valid(dv0), .seq_error(se0), .word_count(wc0),
`ifdef FIFO_READER_UNDERRUN_STATS_EN
    .underrun_count(uc0),
`endif
    .err_count(ec0));

  fifo_periodic_reader #(.DATA_WIDTH(DW), .RD_EN_PERIOD(P1), .START_VALUE(S1)) u_dut1 (
    .clk(clk), .kill(kill), .fifo_empty(empty1), .fifo_rd_en(rd1), .fifo_dout(dout1),
    .data_out(dat1), .data_valid(dv1), .seq_error(se1), .word_count(wc1),
`ifdef FIFO_READER_UNDERRUN_STATS_EN
    .underrun_count(uc1),
`endif
    .err_count(ec1));

  int n_checks = 0;
  int n_errs   = 0;

  // FIFO contents seen by each reader; force_empty makes reader 0's FIFO look empty.
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic        force_empty;
  int          cyc;

  // Reference model, one slot per instance.
  int          per[2];
  logic [11:0] start[2];
  int          rd_at[2], dv_at[2];
  logic [11:0] cap_w[2], m_exp[2];
  int          m_words[2], m_errs[2], m_under[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    empty0 = force_empty || (q0.size() == 0);
    empty1 = (q1.size() == 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rd_at[i] = -1; dv_at[i] = -1; m_exp[i] = start[i];
      m_words[i] = 0; m_errs[i] = 0; m_under[i] = 0;
    end
  endtask

  // Compare one instance's outputs in cycle cyc with the model, then advance the model.
  task automatic check_inst(input int i, input logic rd, input logic dv, input logic se,
                            input logic [11:0] dat, input logic [15:0] wc, input logic [15:0] ec,
                            input logic empty);
    logic exp_rd;
    logic mis;
    exp_rd = (rd_at[i] == cyc);
    chk($sformatf("u%0d rd_en c%0d", i, cyc), 32'(rd), 32'(exp_rd));
    if (exp_rd) dv_at[i] = cyc + 2;
    if (cyc % per[i] == per[i] - 1) begin
      if (empty) m_under[i]++;
      else       rd_at[i] = cyc + 1;
    end
    if (dv_at[i] == cyc) begin
      mis = (cap_w[i] != m_exp[i]);
      m_exp[i] = cap_w[i] + 12'd1;
      m_words[i]++;
      if (mis) m_errs[i]++;
      chk($sformatf("u%0d data_valid c%0d", i, cyc), 32'(dv), 32'd1);
      chk($sformatf("u%0d data_out c%0d", i, cyc), 32'(dat), 32'(cap_w[i]));
      chk($sformatf("u%0d seq_error c%0d", i, cyc), 32'(se), 32'(mis));
      chk($sformatf("u%0d word_count c%0d", i, cyc), 32'(wc), 32'(m_words[i] % 65536));
      chk($sformatf("u%0d err_count c%0d", i, cyc), 32'(ec), 32'(m_errs[i]));
    end else begin
      chk($sformatf("u%0d data_valid c%0d", i, cyc), 32'(dv), 32'd0);
      chk($sformatf("u%0d seq_error c%0d", i, cyc), 32'(se), 32'd0);
    end
  endtask

  // One clock cycle: check at negedge, hand out FIFO data just after the edge ending a read strobe.
  task automatic step();
    check_inst(0, rd0, dv0, se0, dat0, wc0, ec0, empty0);
    check_inst(1, rd1, dv1, se1, dat1, wc1, ec1, empty1);
    @(posedge clk);
    #1;
    if (rd_at[0] == cyc && q0.size() > 0) begin dout0 = q0.pop_front(); cap_w[0] = dout0; end
    else if (dv_at[0] == cyc + 1) dout0 = 12'($urandom);
    if (rd_at[1] == cyc && q1.size() > 0) begin dout1 = q1.pop_front(); cap_w[1] = dout1; end
    else if (dv_at[1] == cyc + 1) dout1 = 12'($urandom);
    cyc++;
    upd_empty();
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    kill = 1'b0;
    #1;
    chk("rst rd_en0", 32'(rd0), 32'd0);
    chk("rst data_out0", 32'(dat0), 32'd0);
    chk("rst data_valid0", 32'(dv0), 32'd0);
    chk("rst seq_error0", 32'(se0), 32'd0);
    chk("rst word_count0", 32'(wc0), 32'd0);
    chk("rst err_count0", 32'(ec0), 32'd0);
    chk("rst data_out1", 32'(dat1), 32'd0);
`ifdef FIFO_READER_UNDERRUN_STATS_EN
    chk("rst underrun0", 32'(uc0), 32'd0);
`endif
    model_reset();
    repeat (hold) @(negedge clk);
    kill = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    logic [11:0] v;
    logic        found;
    per   = '{P0, P1};
    start = '{S0, S1};
    kill = 1'b1; force_empty = 1'b0; cyc = 0;
    dout0 = 12'($urandom); dout1 = 12'($urandom);
    model_reset();
    upd_empty();
    @(negedge clk);

    // Reset held 5 cycles with both FIFOs empty, then 100 idle cycles.
    do_reset(5);
    repeat (100) step();
    chk("idle word_count", 32'(wc0), 32'd0);
    chk("idle err_count", 32'(ec0), 32'd0);

    // Preloaded 0..9 on reader 0; wrap sequence FFE..001 on reader 1.
    for (int k = 0; k < 10; k++) q0.push_back(12'(k));
    q1.push_back(12'hFFE); q1.push_back(12'hFFF); q1.push_back(12'h000); q1.push_back(12'h001);
    upd_empty();
    repeat (10 * P0 + 5) step();
    chk("burst word_count", 32'(wc0), 32'd10);
    chk("burst err_count", 32'(ec0), 32'd0);
    chk("burst last data", 32'(dat0), 32'd9);
    chk("wrap word_count", 32'(wc1), 32'd4);
    chk("wrap err_count", 32'(ec1), 32'd0);
    chk("wrap last data", 32'(dat1), 32'h001);

    // Three ticks with the FIFO reported empty, then word 0.
    do_reset(3);
    q0.push_back(12'h000);
    force_empty = 1'b1;
    upd_empty();
    repeat (106) step();
    force_empty = 1'b0;
    upd_empty();
    repeat (40) step();
    chk("underrun word_count", 32'(wc0), 32'd1);
    chk("underrun err_count", 32'(ec0), 32'd0);
    chk("underrun data_out", 32'(dat0), 32'd0);
`ifdef FIFO_READER_UNDERRUN_STATS_EN
    chk("underrun_count", 32'(uc0), 32'd3);
`endif

    // One dropped word in the stream.
    do_reset(2);
    foreach (q0[k]) q0[k] = 12'h000;
    q0.delete();
    q0.push_back(12'd0); q0.push_back(12'd1); q0.push_back(12'd2); q0.push_back(12'd3);
    q0.push_back(12'd4); q0.push_back(12'd6); q0.push_back(12'd7);
    upd_empty();
    repeat (7 * P0 + 5) step();
    chk("gap word_count", 32'(wc0), 32'd7);
    chk("gap err_count", 32'(ec0), 32'd1);

    // Random stream with random jumps and random empty periods.
    do_reset(2);
    v = 12'h000;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 5) == 0) v = 12'($urandom_range(0, 4095));
      q0.push_back(v);
      v = v + 12'd1;
    end
    upd_empty();
    for (int k = 0; k < 30 * P0; k++) begin
      if (k % 10 == 0) force_empty = ($urandom_range(0, 3) == 0);
      upd_empty();
      step();
    end
    force_empty = 1'b0;
    upd_empty();
    for (int k = 0; k < 30 * P0 && (q0.size() > 0 || dv_at[0] >= cyc); k++) step();
    repeat (5) step();
    chk("random drained", 32'(q0.size()), 32'd0);
    chk("random word_count", 32'(wc0), 32'(m_words[0]));
    chk("random err_count", 32'(ec0), 32'(m_errs[0]));
`ifdef FIFO_READER_UNDERRUN_STATS_EN
    chk("random underrun_count", 32'(uc0), 32'(m_under[0]));
`endif

    // Kill during the capture of word 5, then check the expected word restarts.
    do_reset(2);
    for (int k = 0; k < 10; k++) q0.push_back(12'(k));
    upd_empty();
    found = 1'b0;
    for (int k = 0; k < 20 * P0 && !found; k++) begin
      if (dv_at[0] == cyc + 1 && cap_w[0] == 12'd5) found = 1'b1;
      else step();
    end
    chk("kill window reached", 32'(found), 32'd1);
    do_reset(3);
    q0.delete();
    q0.push_back(12'h000);
    upd_empty();
    repeat (P0 + 5) step();
    chk("post-kill word_count", 32'(wc0), 32'd1);
    chk("post-kill err_count", 32'(ec0), 32'd0);
    chk("post-kill data_out", 32'(dat0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
